// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: walks a KxK window over every output pixel of every channel, feeds the MAC with
// ifmap beats through a 1-entry skid, and writes saturated results. Build macro: CONV_RELU_EN.
module conv_seq_ctrl #(
    parameter int IMG_W  = 9,
    parameter int IMG_H  = 9,
    parameter int K      = 3,
    parameter int CH     = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_start,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_irq,
    output logic              ifm_rd_en,
    output logic [ADDR_W-1:0] ifm_rd_addr,
    input  logic [DATA_W-1:0] ifm_rd_data,
    output logic              mac_in_valid,
    output logic [DATA_W-1:0] mac_in_data,
    output logic              mac_in_first,
    output logic              mac_in_last,
    input  logic              mac_in_ready,
    input  logic              mac_out_valid,
    input  logic [ACC_W-1:0]  mac_out_data,
    output logic              ofm_wr_en,
    output logic [ADDR_W-1:0] ofm_wr_addr,
    output logic [OUT_W-1:0]  ofm_wr_data
);
    localparam int OH    = IMG_H - K + 1;
    localparam int OW    = IMG_W - K + 1;
    localparam int TOTAL = CH * OH * OW;

    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] OW_LAST = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] OH_LAST = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] CH_LAST = ADDR_W'(CH - 1);
    localparam logic [ADDR_W-1:0] TOTAL_A = ADDR_W'(TOTAL);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] IMG_H_A = ADDR_W'(IMG_H);

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] ch_q, ch_d, oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d;
    logic [ADDR_W-1:0] res_cnt_q, res_cnt_d;
    logic              infl_valid_q, infl_valid_d, infl_first_q, infl_first_d, infl_last_q, infl_last_d;
    logic              skid_full_q, skid_full_d, skid_first_q, skid_first_d, skid_last_q, skid_last_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [OUT_W-1:0]  wr_data_q, wr_data_d;
    logic              irq_q, irq_d;

    logic              start_accept, rd_issue, win_first, win_last, last_read, count_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [OUT_W-1:0]  sat_data;

    assign start_accept = cfg_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign rd_issue     = (state_q == S_RUN) && !skid_full_q && mac_in_ready;
    assign win_first    = (ky_q == '0) && (kx_q == '0);
    assign win_last     = (ky_q == K_LAST) && (kx_q == K_LAST);
    assign last_read    = rd_issue && win_last && (ox_q == OW_LAST) && (oy_q == OH_LAST) && (ch_q == CH_LAST);
    assign count_en     = mac_out_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign rd_addr      = (ch_q * IMG_H_A + oy_q + ky_q) * IMG_W_A + ox_q + kx_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cfg_start) state_d = S_RUN;
            S_RUN:   if (last_read) state_d = S_DRAIN;
            S_DRAIN: if (res_cnt_q == TOTAL_A) state_d = S_DONE;
            S_DONE:  if (cfg_start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        cfg_done     = (state_q == S_DONE);
        cfg_irq      = irq_q;
        ifm_rd_en    = rd_issue;
        ifm_rd_addr  = rd_issue ? rd_addr : '0;
        mac_in_valid = skid_full_q || infl_valid_q;
        mac_in_data  = '0;
        mac_in_first = 1'b0;
        mac_in_last  = 1'b0;
        if (skid_full_q) begin
            mac_in_data  = skid_data_q;
            mac_in_first = skid_first_q;
            mac_in_last  = skid_last_q;
        end else if (infl_valid_q) begin
            mac_in_data  = ifm_rd_data;
            mac_in_first = infl_first_q;
            mac_in_last  = infl_last_q;
        end
        ofm_wr_en   = wr_en_q;
        ofm_wr_addr = wr_addr_q;
        ofm_wr_data = wr_data_q;
    end

    // Window walk: kx innermost, then ky, ox, oy, ch; advances only on an issued read.
    always_comb begin
        ch_d = ch_q;
        oy_d = oy_q;
        ox_d = ox_q;
        ky_d = ky_q;
        kx_d = kx_q;
        if (start_accept) begin
            ch_d = '0;
            oy_d = '0;
            ox_d = '0;
            ky_d = '0;
            kx_d = '0;
        end else if (rd_issue) begin
            if (kx_q == K_LAST) begin
                kx_d = '0;
                if (ky_q == K_LAST) begin
                    ky_d = '0;
                    if (ox_q == OW_LAST) begin
                        ox_d = '0;
                        if (oy_q == OH_LAST) begin
                            oy_d = '0;
                            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + ONE;
                        end else begin
                            oy_d = oy_q + ONE;
                        end
                    end else begin
                        ox_d = ox_q + ONE;
                    end
                end else begin
                    ky_d = ky_q + ONE;
                end
            end else begin
                kx_d = kx_q + ONE;
            end
        end
    end

    // The skid only fills from an in-flight beat; reads are blocked while it is full, so both never hold a beat at once.
    always_comb begin
        infl_valid_d = rd_issue;
        infl_first_d = rd_issue && win_first;
        infl_last_d  = rd_issue && win_last;
        skid_full_d  = skid_full_q;
        skid_data_d  = skid_data_q;
        skid_first_d = skid_first_q;
        skid_last_d  = skid_last_q;
        if (skid_full_q) begin
            if (mac_in_ready) begin
                skid_full_d = 1'b0;
            end
        end else if (infl_valid_q && !mac_in_ready) begin
            skid_full_d  = 1'b1;
            skid_data_d  = ifm_rd_data;
            skid_first_d = infl_first_q;
            skid_last_d  = infl_last_q;
        end
    end

    always_comb begin
        sat_data = mac_out_data[OUT_W-1:0];
        if ($signed(mac_out_data) > SAT_MAX) begin
            sat_data = OUT_MAX;
        end else if ($signed(mac_out_data) < SAT_MIN) begin
            sat_data = OUT_MIN;
        end
`ifdef CONV_RELU_EN
        if (mac_out_data[ACC_W-1]) begin
            sat_data = '0;
        end
`else
`endif
    end

    always_comb begin
        wr_en_d   = count_en;
        wr_addr_d = count_en ? res_cnt_q : '0;
        wr_data_d = count_en ? sat_data : '0;
        res_cnt_d = res_cnt_q;
        if (start_accept) begin
            res_cnt_d = '0;
        end else if (count_en) begin
            res_cnt_d = res_cnt_q + ONE;
        end
        irq_d = (state_q == S_DRAIN) && (state_d == S_DONE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ch_q         <= '0;
            oy_q         <= '0;
            ox_q         <= '0;
            ky_q         <= '0;
            kx_q         <= '0;
            res_cnt_q    <= '0;
            infl_valid_q <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            skid_full_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_first_q <= 1'b0;
            skid_last_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            ch_q         <= ch_d;
            oy_q         <= oy_d;
            ox_q         <= ox_d;
            ky_q         <= ky_d;
            kx_q         <= kx_d;
            res_cnt_q    <= res_cnt_d;
            infl_valid_q <= infl_valid_d;
            infl_first_q <= infl_first_d;
            infl_last_q  <= infl_last_d;
            skid_full_q  <= skid_full_d;
            skid_data_q  <= skid_data_d;
            skid_first_q <= skid_first_d;
            skid_last_q  <= skid_last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            irq_q        <= irq_d;
        end
    end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench for conv_seq_ctrl; expected beats and ofmap writes are queued
// from a bench-side window model when a run starts and popped as the DUT produces them.
module tb_conv_seq_ctrl;
    localparam int IMG_W = 9;
    localparam int IMG_H = 9;
    localparam int K     = 3;
    localparam int CH    = 2;
    localparam int OH    = IMG_H - K + 1;
    localparam int OW    = IMG_W - K + 1;
    localparam int TOTAL = CH * OH * OW;
    localparam int NPIX  = CH * IMG_H * IMG_W;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
    } beat_t;

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_busy, cfg_done, cfg_irq;
    logic        ifm_rd_en;
    logic [11:0] ifm_rd_addr;
    logic [7:0]  ifm_rd_data;
    logic        mac_in_valid, mac_in_first, mac_in_last;
    logic [7:0]  mac_in_data;
    logic        mac_in_ready = 1'b1;
    logic        mac_out_valid = 1'b0;
    logic [31:0] mac_out_data = '0;
    logic        ofm_wr_en;
    logic [11:0] ofm_wr_addr;
    logic [15:0] ofm_wr_data;

    logic [7:0]  mem [NPIX];
    beat_t       beatQ[$];
    wr_t         wrQ[$];
    beat_t       bExp;
    wr_t         wExp;

    int          checks = 0;
    int          errors = 0;
    int          wrCount = 0;
    int          irqCount = 0;
    int          macWin = 0;
    bit          useOvr = 1'b0;
    bit          injectValid = 1'b0;
    bit          resPending = 1'b0;
    logic [31:0] resVal = '0;
    logic [31:0] acc = '0;
    bit          prevStall = 1'b0;
    logic [9:0]  prevBeat = '0;

    wire logic [55:0] allOut = {cfg_busy, cfg_done, cfg_irq, ifm_rd_en, ifm_rd_addr, mac_in_valid,
                                mac_in_data, mac_in_first, mac_in_last, ofm_wr_en, ofm_wr_addr, ofm_wr_data};

    conv_seq_ctrl dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cfg_start     (cfg_start),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_irq       (cfg_irq),
        .ifm_rd_en     (ifm_rd_en),
        .ifm_rd_addr   (ifm_rd_addr),
        .ifm_rd_data   (ifm_rd_data),
        .mac_in_valid  (mac_in_valid),
        .mac_in_data   (mac_in_data),
        .mac_in_first  (mac_in_first),
        .mac_in_last   (mac_in_last),
        .mac_in_ready  (mac_in_ready),
        .mac_out_valid (mac_out_valid),
        .mac_out_data  (mac_out_data),
        .ofm_wr_en     (ofm_wr_en),
        .ofm_wr_addr   (ofm_wr_addr),
        .ofm_wr_data   (ofm_wr_data)
    );

    always #5 ACLK = ~ACLK;

    // Ifmap buffer with one cycle of read latency.
    always @(posedge ACLK) begin
        if (ifm_rd_en) ifm_rd_data <= mem[ifm_rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] satModel(input logic signed [31:0] v);
        logic [15:0] r;
        if (v > 32'sd32767) r = 16'h7FFF;
        else if (v < -32'sd32768) r = 16'h8000;
        else r = v[15:0];
`ifdef CONV_RELU_EN
        if (v < 0) r = 16'h0000;
`endif
        return r;
    endfunction

    function automatic logic [31:0] ovrVal(input int i);
        case (i % 6)
            0:       return 32'h0001_2345;
            1:       return 32'hFFFF_0000;
            2:       return 32'hFFFF_FFFB;
            3:       return 32'h0000_7FFF;
            4:       return 32'h0000_8000;
            default: return 32'hFFFF_8000;
        endcase
    endfunction

    task automatic pushRun();
        int idx;
        logic [31:0] sum;
        beat_t b;
        wr_t w;
        idx = 0;
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < OH; y++)
                for (int x = 0; x < OW; x++) begin
                    sum = '0;
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            b.d = mem[(c * IMG_H + y + ky) * IMG_W + x + kx];
                            b.f = (ky == 0) && (kx == 0);
                            b.l = (ky == K - 1) && (kx == K - 1);
                            beatQ.push_back(b);
                            sum = sum + 32'(b.d);
                        end
                    w.a = 12'(idx);
                    w.d = satModel(useOvr ? ovrVal(idx) : sum);
                    wrQ.push_back(w);
                    idx++;
                end
    endtask

    // MAC model and output monitor; inputs are driven and outputs sampled on the falling edge.
    always @(negedge ACLK) begin
        mac_out_valid = 1'b0;
        mac_out_data  = '0;
        if (ARESET) begin
            resPending = 1'b0;
            prevStall  = 1'b0;
        end else begin
            if (resPending) begin
                mac_out_valid = 1'b1;
                mac_out_data  = resVal;
                resPending    = 1'b0;
            end else if (injectValid) begin
                mac_out_valid = 1'b1;
                mac_out_data  = 32'd5;
                injectValid   = 1'b0;
            end
            if (prevStall) begin
                checkOutput("stall_hold", {mac_in_valid, mac_in_data, mac_in_first, mac_in_last}, {1'b1, prevBeat});
                checkOutput("no_read_skid", ifm_rd_en, 0);
            end
            if (!mac_in_ready) checkOutput("no_read_stall", ifm_rd_en, 0);
            prevStall = mac_in_valid && !mac_in_ready;
            prevBeat  = {mac_in_data, mac_in_first, mac_in_last};
            if (mac_in_valid && mac_in_ready) begin
                checkOutput("beat_expected", 64'(beatQ.size() != 0), 1);
                if (beatQ.size() != 0) begin
                    bExp = beatQ.pop_front();
                    checkOutput("beat", {mac_in_data, mac_in_first, mac_in_last}, {bExp.d, bExp.f, bExp.l});
                end
                acc = mac_in_first ? 32'(mac_in_data) : acc + 32'(mac_in_data);
                if (mac_in_last) begin
                    resPending = 1'b1;
                    resVal     = useOvr ? ovrVal(macWin) : acc;
                    macWin++;
                end
            end
            if (ofm_wr_en) begin
                wrCount++;
                checkOutput("wr_expected", 64'(wrQ.size() != 0), 1);
                if (wrQ.size() != 0) begin
                    wExp = wrQ.pop_front();
                    checkOutput("ofm_write", {ofm_wr_addr, ofm_wr_data}, {wExp.a, wExp.d});
                end
            end
            if (cfg_irq) begin
                irqCount++;
                checkOutput("irq_in_done", cfg_done, 1);
            end
        end
    end

    task automatic applyStimulus();
        cfg_start = 1'b1;
        @(posedge ACLK); #1;
        cfg_start = 1'b0;
    endtask

    task automatic finishRun();
        checkOutput("done_reached", cfg_done, 1);
        repeat (2) @(posedge ACLK);
        #1;
        checkOutput("write_count", 64'(wrCount), 64'(TOTAL));
        checkOutput("irq_count", 64'(irqCount), 1);
        checkOutput("beats_left", 64'(beatQ.size()), 0);
        checkOutput("writes_left", 64'(wrQ.size()), 0);
        checkOutput("busy_after_done", cfg_busy, 0);
        checkOutput("done_level", cfg_done, 1);
        checkOutput("irq_is_pulse", cfg_irq, 0);
    endtask

    task automatic runOne(input bit stall, input bit pulseMid);
        int n;
        irqCount = 0;
        wrCount  = 0;
        macWin   = 0;
        applyStimulus();
        checkOutput("busy_after_start", cfg_busy, 1);
        checkOutput("done_dropped", cfg_done, 0);
        n = 0;
        while (!cfg_done && n < 20000) begin
            mac_in_ready = stall ? !((n % 13) inside {5, 6, 7}) : 1'b1;
            cfg_start    = pulseMid && (n == 100);
            if (pulseMid && n == 100) checkOutput("busy_mid_run", cfg_busy, 1);
            @(posedge ACLK); #1;
            n++;
        end
        cfg_start    = 1'b0;
        mac_in_ready = 1'b1;
        finishRun();
    endtask

    initial begin
        int n;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd1;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("reset_outputs", allOut, 0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("idle_busy", cfg_busy, 0);
        checkOutput("idle_done", cfg_done, 0);

        $display("[TB] all-ones ifmap, ready held high");
        useOvr = 1'b0;
        pushRun();
        runOne(1'b0, 1'b0);

        $display("[TB] mac_out_valid while DONE");
        injectValid = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("done_ignores_result", 64'(wrCount), 64'(TOTAL));
        checkOutput("done_still_set", cfg_done, 1);

        $display("[TB] ramp ifmap, periodic 3-cycle stalls, start pulsed mid-run");
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        pushRun();
        runOne(1'b1, 1'b1);

        $display("[TB] saturation via overridden MAC results");
        useOvr = 1'b1;
        pushRun();
        runOne(1'b0, 1'b0);
        useOvr = 1'b0;

        $display("[TB] reset after 40 results, then full rerun");
        pushRun();
        irqCount = 0;
        wrCount  = 0;
        macWin   = 0;
        applyStimulus();
        n = 0;
        while (wrCount < 40 && n < 5000) begin
            @(posedge ACLK); #1;
            n++;
        end
        checkOutput("reached_40_results", 64'(wrCount), 40);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        checkOutput("abort_outputs", allOut, 0);
        beatQ.delete();
        wrQ.delete();
        @(posedge ACLK); #1;
        pushRun();
        runOne(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
